// File: rtl/exec_unit_if.sv
// Issue and write-back bundle between the operand source, exec_unit and the register file write port.
interface exec_unit_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [AW-1:0] dst;
    logic          busy;
    logic          wb_en;
    logic [AW-1:0] wb_sel;
    logic [DW-1:0] wb_data;
    logic          flag_z;
    logic          flag_c;
    logic          flag_n;

    modport master (
        output start, op, opa, opb, dst,
        input  busy, wb_en, wb_sel, wb_data, flag_z, flag_c, flag_n
    );

    modport slave (
        input  start, op, opa, opb, dst,
        output busy, wb_en, wb_sel, wb_data, flag_z, flag_c, flag_n
    );
endinterface

// File: rtl/exec_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus a shift-add multiplier, driving the register file write port.
// Define EXEC_MUL_EN to build the multi-cycle MUL path; without it op 111 retires with no write.
module exec_unit #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int MUL_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    exec_unit_if.slave  bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam int            CW       = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYC - 1);
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WB   = 1'b1
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic load_alu;
    logic write_d;
`ifdef EXEC_MUL_EN
    logic load_mul;
    logic mul_step;
    logic mul_done;
`endif

    logic [DW:0]   alu_full;
    logic          wb_en_q;
    logic [AW-1:0] wb_sel_q;
    logic [DW-1:0] wb_data_q;
    logic          flag_z_q;
    logic          flag_c_q;
    logic          flag_n_q;

`ifdef EXEC_MUL_EN
    logic [2*DW-1:0] mcand_q;
    logic [2*DW-1:0] acc_q;
    logic [2*DW-1:0] acc_next;
    logic [DW-1:0]   mplier_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   dst_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Starts are only accepted in IDLE; WB always falls back to IDLE so the bus sees one pulse per op.
    always_comb begin
        state_d  = state_q;
        load_alu = 1'b0;
        write_d  = 1'b0;
`ifdef EXEC_MUL_EN
        load_mul = 1'b0;
        mul_step = 1'b0;
        mul_done = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
`ifdef EXEC_MUL_EN
                        load_mul = 1'b1;
                        state_d  = ST_MUL;
`else
                        state_d  = ST_WB;
`endif
                    end else begin
                        load_alu = 1'b1;
                        write_d  = 1'b1;
                        state_d  = ST_WB;
                    end
                end
            end
`ifdef EXEC_MUL_EN
            ST_MUL: begin
                mul_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    mul_done = 1'b1;
                    write_d  = 1'b1;
                    state_d  = ST_WB;
                end
            end
`endif
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The top bit of alu_full carries the C flag for every single-cycle op.
    always_comb begin
        alu_full = '0;
        case (bus.op)
            OP_ADD:  alu_full = {1'b0, bus.opa} + {1'b0, bus.opb};
            OP_SUB:  alu_full = {1'b0, bus.opa} - {1'b0, bus.opb};
            OP_AND:  alu_full = {1'b0, bus.opa & bus.opb};
            OP_OR:   alu_full = {1'b0, bus.opa | bus.opb};
            OP_XOR:  alu_full = {1'b0, bus.opa ^ bus.opb};
            OP_SHL:  alu_full = {bus.opa, 1'b0};
            OP_SHR:  alu_full = {bus.opa[0], 1'b0, bus.opa[DW-1:1]};
            default: alu_full = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
        end else if (load_mul) begin
            mcand_q  <= {{DW{1'b0}}, bus.opa};
            mplier_q <= bus.opb;
            acc_q    <= '0;
            cnt_q    <= '0;
            dst_q    <= bus.dst;
        end else if (mul_step) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end
`endif

    // Result, destination and flags only move on a real write-back and hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en_q   <= 1'b0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_n_q  <= 1'b0;
        end else begin
            wb_en_q <= write_d;
            if (load_alu) begin
                wb_sel_q  <= bus.dst;
                wb_data_q <= alu_full[DW-1:0];
                flag_z_q  <= (alu_full[DW-1:0] == '0);
                flag_c_q  <= alu_full[DW];
                flag_n_q  <= alu_full[DW-1];
            end
`ifdef EXEC_MUL_EN
            if (mul_done) begin
                wb_sel_q  <= dst_q;
                wb_data_q <= acc_next[DW-1:0];
                flag_z_q  <= (acc_next[DW-1:0] == '0);
                flag_c_q  <= |acc_next[2*DW-1:DW];
                flag_n_q  <= acc_next[DW-1];
            end
`endif
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_sel  = wb_sel_q;
    assign bus.wb_data = wb_data_q;
    assign bus.flag_z  = flag_z_q;
    assign bus.flag_c  = flag_c_q;
    assign bus.flag_n  = flag_n_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus random ops against an arithmetic reference model.
module tb_exec_unit;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    int m_data = 0;
    int m_sel  = 0;
    bit m_z    = 1'b0;
    bit m_c    = 1'b0;
    bit m_n    = 1'b0;

    exec_unit_if #(.DW(8), .AW(3)) bus ();

    exec_unit #(.DW(8), .AW(3), .MUL_CYC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour from the op definitions, using plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b,
                                  output bit wr, output int res, output bit c);
        int p;
        wr  = 1'b1;
        res = 0;
        c   = 1'b0;
        case (op)
            0: begin p = a + b; res = p % 256; c = (p > 255); end
            1: begin res = (a - b + 256) % 256; c = (a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 256; c = (a >= 128); end
            6: begin res = a / 2; c = (a % 2 == 1); end
            default: begin
                p   = a * b;
                res = p % 256;
                c   = (p > 255);
                wr  = MUL_EN;
            end
        endcase
    endfunction

    task automatic check_state(input string tag);
        check_output({tag, " data"}, bus.wb_data, m_data);
        check_output({tag, " sel"},  bus.wb_sel,  m_sel);
        check_output({tag, " z"},    bus.flag_z,  m_z);
        check_output({tag, " c"},    bus.flag_c,  m_c);
        check_output({tag, " n"},    bus.flag_n,  m_n);
    endtask

    task automatic apply_stimulus(input string tag, input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [2:0] d, input bit noise);
        bit wr;
        int res;
        bit c;
        int exp_busy;
        int exp_lat;
        int lat;
        int pulses;
        int busy_cycles;
        model(int'(op), int'(a), int'(b), wr, res, c);
        exp_busy = (op == 3'd7 && MUL_EN) ? 9 : 1;
        exp_lat  = wr ? exp_busy : 0;
        if (wr) begin
            m_data = res;
            m_sel  = int'(d);
            m_c    = c;
            m_z    = (res == 0);
            m_n    = (res >= 128);
        end
        @(negedge clk);
        check_output({tag, " idle"}, bus.busy, 0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        bus.dst   = d;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat         = 0;
        pulses      = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.wb_en) begin
                pulses++;
                lat = k;
            end
            if (noise && k <= exp_busy) begin
                bus.start = 1'b1;
                bus.op    = 3'($urandom_range(0, 7));
                bus.opa   = 8'($urandom);
                bus.opb   = 8'($urandom);
                bus.dst   = 3'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        check_output({tag, " pulses"}, pulses, wr ? 1 : 0);
        check_output({tag, " latency"}, lat, exp_lat);
        check_output({tag, " busy cycles"}, busy_cycles, exp_busy);
        check_output({tag, " end busy"}, bus.busy, 0);
        check_state(tag);
    endtask

    task automatic clear_model();
        m_data = 0;
        m_sel  = 0;
        m_z    = 1'b0;
        m_c    = 1'b0;
        m_n    = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.opa   = 8'd0;
        bus.opb   = 8'd0;
        bus.dst   = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("reset busy", bus.busy, 0);
        check_output("reset wb_en", bus.wb_en, 0);
        check_state("reset");

        apply_stimulus("add f0+20", 3'd0, 8'hF0, 8'h20, 3'd3, 1'b0);
        apply_stimulus("sub 5-5",   3'd1, 8'h05, 8'h05, 3'd1, 1'b0);
        apply_stimulus("sub 3-5",   3'd1, 8'h03, 8'h05, 3'd2, 1'b0);
        apply_stimulus("shl 81",    3'd5, 8'h81, 8'hFF, 3'd0, 1'b0);
        apply_stimulus("shr 03",    3'd6, 8'h03, 8'h00, 3'd4, 1'b0);
        apply_stimulus("mul 0d*0b", 3'd7, 8'h0D, 8'h0B, 3'd7, 1'b0);
        apply_stimulus("mul 20*10", 3'd7, 8'h20, 8'h10, 3'd5, 1'b0);
        apply_stimulus("mul noisy", 3'd7, 8'h0D, 8'h0B, 3'd6, 1'b1);
        apply_stimulus("xor noisy", 3'd4, 8'hA5, 8'h5A, 3'd2, 1'b1);

        // Abort an in-flight op with an asynchronous reset; nothing may be written back.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MUL_EN ? 3'd7 : 3'd0;
        bus.opa   = 8'hFF;
        bus.opb   = 8'hFF;
        bus.dst   = 3'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (MUL_EN ? 4 : 1) @(negedge clk);
        reset = 1'b0;
        #1;
        clear_model();
        check_output("abort busy", bus.busy, 0);
        check_output("abort wb_en", bus.wb_en, 0);
        check_state("abort");
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus("add 1+1", 3'd0, 8'h01, 8'h01, 3'd1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            apply_stimulus($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), 8'($urandom),
                           8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
